// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared mode encodings, scan state type and default geometry
//                for the LED-matrix scan sequencer and matrix driver.
//  Revision    : 1.0  initial release
// ============================================================================
package matrix_pkg;

    localparam logic [1:0] MODE_WRAP     = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_BASE_ADDR    = 32'h0000_0100;
    localparam int DEF_ROWS         = 16;
    localparam int DEF_COLS         = 16;
    localparam int DEF_BLANK_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // The reserved encoding behaves as continuous wrap.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_WRAP : m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_rc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_rc_counter
//  Description : Row/column scan counter, up or down, with load-zero,
//                load-max, single step and end-of-row / end-of-frame flags.
//  Revision    : 1.0  initial release
// ============================================================================
module matrix_rc_counter
    import matrix_pkg::*;
#(
    parameter int  ROWS  = DEF_ROWS,
    parameter int  COLS  = DEF_COLS,
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_zero_i,
    input  logic             load_max_i,
    input  logic             step_i,
    input  logic             dir_down_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             row_last_o,
    output logic             frame_last_o
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             w_col_end;
    logic             w_row_end;

    // "End" is direction-relative: the far corner of an up frame is the
    // starting corner of a down frame and vice versa.
    always_comb begin
        w_col_end = dir_down_i ? (col_q == '0) : (col_q == COL_MAX);
        w_row_end = dir_down_i ? (row_q == '0) : (row_q == ROW_MAX);
        row_d     = row_q;
        col_d     = col_q;
        if (load_zero_i) begin
            row_d = '0;
            col_d = '0;
        end else if (load_max_i) begin
            row_d = ROW_MAX;
            col_d = COL_MAX;
        end else if (step_i) begin
            if (w_col_end) begin
                col_d = dir_down_i ? COL_MAX : '0;
                row_d = dir_down_i ? (row_q - 1'b1) : (row_q + 1'b1);
            end else begin
                col_d = dir_down_i ? (col_q - 1'b1) : (col_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o        = row_q;
    assign col_o        = col_q;
    assign row_last_o   = w_col_end;
    assign frame_last_o = w_col_end & w_row_end;

endmodule
`default_nettype wire

// File: rtl/matrix_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_scan_seq
//  Description : LED-matrix scan address sequencer with valid/ready output,
//                wrap / one-shot / ping-pong frames and row/frame strobes.
//                Optional per-row blanking is built when SCAN_BLANK_EN is
//                defined.
//  Revision    : 1.0  initial release
// ============================================================================
module matrix_scan_seq
    import matrix_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DEF_BASE_ADDR),
    parameter int                ROWS         = DEF_ROWS,
    parameter int                COLS         = DEF_COLS,
    parameter int                BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int               ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int               COL_W        = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              reset_arduino,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              row_done,
    output logic              frame_done,
    output logic              busy,
    output logic              blank
);

    if (ROWS < 1 || COLS < 1 || BLANK_CYCLES < 1) begin : g_param_check
        $error("matrix_scan_seq: ROWS, COLS and BLANK_CYCLES must be >= 1");
    end

    scan_state_t state_q;
    logic [1:0]  mode_q;
    logic        dir_q;
    logic        valid_q;
    logic        row_done_q;
    logic        frame_done_q;
    logic        busy_q;

    logic        w_xfer;
    logic        w_load_zero;
    logic        w_load_max;
    logic        w_step;
    logic        w_row_last;
    logic        w_frame_last;

`ifdef SCAN_BLANK_EN
    localparam int               BLK_W     = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLK_W-1:0] BLANK_MAX = BLK_W'(BLANK_CYCLES - 1);

    logic             blank_q;
    logic [BLK_W-1:0] blank_cnt_q;
    logic             done_pending_q;
`endif

    assign w_xfer = valid_q & addr_ready;

    // Counter commands. At a frame end the counter is parked for the next
    // frame: back to origin for wrap, far corner kept for ping-pong.
    always_comb begin
        w_load_zero = 1'b0;
        w_load_max  = 1'b0;
        w_step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_load_zero = 1'b1;
                end
            end
            ST_DONE: begin
                w_load_zero = 1'b1;
            end
            default: begin
                if (stop) begin
                    w_load_zero = 1'b1;
                end else if (state_q == ST_SCAN && w_xfer) begin
                    if (!w_frame_last) begin
                        w_step = 1'b1;
                    end else if (mode_q == MODE_WRAP) begin
                        w_load_zero = 1'b1;
                    end else if (mode_q == MODE_PINGPONG) begin
                        w_load_zero = dir_q;
                        w_load_max  = ~dir_q;
                    end
                end
            end
        endcase
    end

    matrix_rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_rc_counter (
        .clk          (clk),
        .rst_n        (reset_arduino),
        .load_zero_i  (w_load_zero),
        .load_max_i   (w_load_max),
        .step_i       (w_step),
        .dir_down_i   (dir_q),
        .row_o        (row),
        .col_o        (col),
        .row_last_o   (w_row_last),
        .frame_last_o (w_frame_last)
    );

    always_ff @(posedge clk or negedge reset_arduino) begin
        if (!reset_arduino) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_WRAP;
            dir_q          <= 1'b0;
            valid_q        <= 1'b0;
            row_done_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            busy_q         <= 1'b0;
`ifdef SCAN_BLANK_EN
            blank_q        <= 1'b0;
            blank_cnt_q    <= '0;
            done_pending_q <= 1'b0;
`endif
        end else begin
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q <= ST_SCAN;
                        mode_q  <= norm_mode(mode);
                        dir_q   <= 1'b0;
                        valid_q <= enable;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        dir_q   <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!valid_q) begin
                        valid_q <= enable;
                    end else if (addr_ready) begin
                        // A launched address stays up until accepted; enable
                        // only gates the launch of the following one.
                        valid_q <= enable;
                        if (w_row_last) begin
                            row_done_q <= 1'b1;
                        end
                        if (w_frame_last) begin
                            frame_done_q <= 1'b1;
                            if (mode_q == MODE_PINGPONG) begin
                                dir_q <= ~dir_q;
                            end
                        end
`ifdef SCAN_BLANK_EN
                        if (w_row_last) begin
                            state_q        <= ST_BLANK;
                            valid_q        <= 1'b0;
                            blank_q        <= 1'b1;
                            blank_cnt_q    <= BLANK_MAX;
                            done_pending_q <= w_frame_last && (mode_q == MODE_ONESHOT);
                        end
`else
                        if (w_frame_last && mode_q == MODE_ONESHOT) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                        end
`endif
                    end
                end
                ST_BLANK: begin
`ifdef SCAN_BLANK_EN
                    if (stop) begin
                        state_q <= ST_IDLE;
                        dir_q   <= 1'b0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        blank_q <= 1'b0;
                    end else if (blank_cnt_q == '0) begin
                        blank_q <= 1'b0;
                        if (done_pending_q) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_SCAN;
                            valid_q <= enable;
                        end
                    end else begin
                        blank_cnt_q <= blank_cnt_q - 1'b1;
                    end
`else
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    dir_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_out   = BASE_ADDR + (ADDR_W'(row) * ADDR_W'(COLS)) + ADDR_W'(col);
    assign addr_valid = valid_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
`ifdef SCAN_BLANK_EN
    assign blank      = blank_q;
`else
    assign blank      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_scan_seq
//  Description : Directed, scoreboard-based bench for matrix_scan_seq
//                (16x16 window at 0x0100; follows SCAN_BLANK_EN if defined).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_matrix_scan_seq;
    import matrix_pkg::*;

    logic        clk = 1'b0;
    logic        reset_arduino;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic        enable;
    logic [15:0] addr_out;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        addr_valid;
    logic        addr_ready;
    logic        row_done;
    logic        frame_done;
    logic        busy;
    logic        blank;

    typedef struct packed {
        logic [15:0] addr;
        logic        row_end;
        logic        frame_end;
    } sb_t;

    sb_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    matrix_scan_seq #(
        .ADDR_W       (16),
        .BASE_ADDR    (16'h0100),
        .ROWS         (16),
        .COLS         (16),
        .BLANK_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset_arduino (reset_arduino),
        .start         (start),
        .stop          (stop),
        .mode          (mode),
        .enable        (enable),
        .addr_out      (addr_out),
        .row           (row),
        .col           (col),
        .addr_valid    (addr_valid),
        .addr_ready    (addr_ready),
        .row_done      (row_done),
        .frame_done    (frame_done),
        .busy          (busy),
        .blank         (blank)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Up frames count idx 0..255, down frames 255..0; a row ends at the
    // direction-relative last column.
    task automatic push_frame(input bit down);
        sb_t e;
        int  idx;
        for (int i = 0; i < 256; i++) begin
            idx         = down ? (255 - i) : i;
            e.addr      = 16'(32'h0100 + idx);
            e.row_end   = down ? ((idx % 16) == 0) : ((idx % 16) == 15);
            e.frame_end = (i == 255);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_range(input int lo, input int hi);
        sb_t e;
        for (int a = lo; a <= hi; a++) begin
            e.addr      = 16'(a);
            e.row_end   = (((a - 32'h0100) % 16) == 15);
            e.frame_end = (a == 32'h01FF);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_valid(input string tag);
        int guard = 0;
        while (addr_valid !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (addr_valid !== 1'b1) chk(tag, 32'(addr_valid), 32'd1);
    endtask

    // Consume n transfers with ready held high; compare each against the
    // scoreboard head and check the strobes one cycle later.
    task automatic xfer(input int n);
        sb_t e;
        for (int k = 0; k < n; k++) begin
            wait_valid("valid_timeout");
            if (addr_valid !== 1'b1) return;
            if (exp_q.size() == 0) begin
                chk("sb_level", 32'(exp_q.size()), 32'd1);
                return;
            end
            e = exp_q.pop_front();
            chk("addr", 32'(addr_out), 32'(e.addr));
            @(negedge clk);
            chk("row_done", 32'(row_done), 32'(e.row_end));
            chk("frame_done", 32'(frame_done), 32'(e.frame_end));
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_valid", 32'(addr_valid), 32'd1);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_valid", 32'(addr_valid), 32'd0);
        chk("stop_addr", 32'(addr_out), 32'h0100);
        chk("stop_row_done", 32'(row_done), 32'd0);
        chk("stop_frame_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        addr_ready = 1'b1;
        enable     = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_arduino = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        mode          = MODE_WRAP;
        enable        = 1'b1;
        addr_ready    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(addr_out), 32'h0100);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {30'd0, row_done, frame_done}, 32'd0);
        chk("rst_blank", 32'(blank), 32'd0);
        reset_arduino = 1'b1;
        @(negedge clk);

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", 32'(busy), 32'd0);
        chk("startstop_valid", 32'(addr_valid), 32'd0);

        // continuous wrap: full frame then restart at the origin
        do_start(MODE_WRAP);
        push_frame(1'b0);
        xfer(256);
        chk("wrap_busy", 32'(busy), 32'd1);
        push_range(32'h0100, 32'h0100);
        xfer(1);
        do_stop();

        // one-shot: DONE for one cycle, start ignored there
        do_start(MODE_ONESHOT);
        push_frame(1'b0);
        xfer(256);
`ifdef SCAN_BLANK_EN
        for (int i = 0; i < 4; i++) begin
            chk("oneshot_blank", 32'(blank), 32'd1);
            chk("oneshot_blank_valid", 32'(addr_valid), 32'd0);
            @(negedge clk);
        end
`endif
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(addr_valid), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("after_done_busy", 32'(busy), 32'd0);
        chk("after_done_valid", 32'(addr_valid), 32'd0);
        @(negedge clk);
        chk("done_start_ignored", 32'(busy), 32'd0);

        // ping-pong: up, down, then up again
        do_start(MODE_PINGPONG);
        push_frame(1'b0);
        push_frame(1'b1);
        push_range(32'h0100, 32'h0100);
        xfer(513);
        do_stop();

        // backpressure with enable dropped while an address is pending
        do_start(MODE_WRAP);
        push_range(32'h0100, 32'h0122);
        xfer(32'h23);
        wait_valid("bp_valid_timeout");
        addr_ready = 1'b0;
        enable     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_addr", 32'(addr_out), 32'h0123);
            chk("bp_valid", 32'(addr_valid), 32'd1);
            @(negedge clk);
        end
        addr_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("bp_paused_valid", 32'(addr_valid), 32'd0);
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("bp_resume_valid", 32'(addr_valid), 32'd1);
        chk("bp_resume_addr", 32'(addr_out), 32'h0124);
        do_stop();

        // stop mid-handshake at 0x0150
        do_start(MODE_WRAP);
        push_range(32'h0100, 32'h014F);
        xfer(32'h50);
        wait_valid("stop_valid_timeout");
        addr_ready = 1'b0;
        @(negedge clk);
        chk("pre_stop_addr", 32'(addr_out), 32'h0150);
        chk("pre_stop_valid", 32'(addr_valid), 32'd1);
        do_stop();

        // asynchronous reset mid-scan
        do_start(MODE_WRAP);
        push_range(32'h0100, 32'h01FE);
        xfer(32'hF0);
        #2;
        reset_arduino = 1'b0;
        #1;
        chk("arst_addr", 32'(addr_out), 32'h0100);
        chk("arst_rowcol", {24'd0, row, col}, 32'd0);
        chk("arst_valid", 32'(addr_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_strobes", {29'd0, row_done, frame_done, blank}, 32'd0);
        @(negedge clk);
        chk("arst_no_frame_done", 32'(frame_done), 32'd0);
        reset_arduino = 1'b1;
        exp_q.delete();
        @(negedge clk);

        // row boundary 0x010F -> 0x0110, with or without blanking
        do_start(MODE_WRAP);
        push_range(32'h0100, 32'h010E);
        xfer(15);
        wait_valid("row_valid_timeout");
        chk("row_end_addr", 32'(addr_out), 32'h010F);
        @(negedge clk);
        chk("row_end_row_done", 32'(row_done), 32'd1);
        chk("row_end_frame_done", 32'(frame_done), 32'd0);
`ifdef SCAN_BLANK_EN
        for (int i = 0; i < 4; i++) begin
            chk("blank_active", 32'(blank), 32'd1);
            chk("blank_valid", 32'(addr_valid), 32'd0);
            @(negedge clk);
        end
`endif
        chk("next_row_blank", 32'(blank), 32'd0);
        chk("next_row_valid", 32'(addr_valid), 32'd1);
        chk("next_row_addr", 32'(addr_out), 32'h0110);
        do_stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
